// File: rtl/mdu_iter_if.sv
// Handshake/result bundle between the E stage and the iterative multiply/divide unit.
// The master issues operations; the slave (mdu_iter) returns Busy and the committed HI/LO.
interface mdu_iter_if;
  logic        Req;
  logic        Start;
  logic [2:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output Req, Start, MDUOp, A, B,
    input  Busy, HI, LO
  );

  modport slave (
    input  Req, Start, MDUOp, A, B,
    output Busy, HI, LO
  );
endinterface

// File: rtl/mdu_iter.sv
// Fixed-latency multiply/divide responder: computes at accept, holds the result, commits to HI/LO.
// Define MDU_MADD_EN to implement MADD/MSUB (codes 6/7); otherwise those codes are ignored.
module mdu_iter #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic      clk,
  input logic      reset,
  mdu_iter_if.slave bus
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] MUL_LAT = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAT = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MSUB  = 3'd7
  } mdu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic [31:0]      hi_q, lo_q;
  logic [31:0]      pend_hi, pend_lo;
  logic             pend_commit;

  mdu_op_e          op;
  logic signed [63:0] prod_s;
  logic [63:0]      prod_u;
  logic             div_fixup;
  logic signed [31:0] sdivisor, quot_s, rem_s;
  logic [31:0]      udivisor, quot_u, rem_u;
  logic [63:0]      res;
  logic             res_commit;
  logic             op_valid;
  logic             op_long;
  logic [CNT_W-1:0] op_lat;
  logic             accept;

  assign op = mdu_op_e'(bus.MDUOp);

  // Arithmetic datapath; operands are consumed only in the accept cycle.
  always_comb begin
    prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
    prod_u = {32'b0, bus.A} * {32'b0, bus.B};
    // Dividing by 1 yields the architectural answer for the INT_MIN / -1 overflow
    // (quotient 0x80000000, remainder 0) and keeps the divide-by-zero path X-free.
    div_fixup = (bus.B == 32'd0) || (bus.A == 32'h8000_0000 && bus.B == 32'hFFFF_FFFF);
    sdivisor  = div_fixup ? 32'sd1 : $signed(bus.B);
    quot_s    = $signed(bus.A) / sdivisor;
    rem_s     = $signed(bus.A) % sdivisor;
    udivisor  = (bus.B == 32'd0) ? 32'd1 : bus.B;
    quot_u    = bus.A / udivisor;
    rem_u     = bus.A % udivisor;
  end

  // Operation decode.
  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    res        = 64'd0;
    res_commit = 1'b0;
    op_valid   = 1'b0;
    op_long    = 1'b0;
    op_lat     = MUL_LAT;
    unique case (op)
      OP_MULT: begin
        res = prod_s; res_commit = 1'b1; op_valid = 1'b1; op_long = 1'b1;
      end
      OP_MULTU: begin
        res = prod_u; res_commit = 1'b1; op_valid = 1'b1; op_long = 1'b1;
      end
      OP_DIV: begin
        res        = {rem_s, quot_s};
        res_commit = (bus.B != 32'd0);
        op_valid   = 1'b1;
        op_long    = 1'b1;
        op_lat     = DIV_LAT;
      end
      OP_DIVU: begin
        res        = {rem_u, quot_u};
        res_commit = (bus.B != 32'd0);
        op_valid   = 1'b1;
        op_long    = 1'b1;
        op_lat     = DIV_LAT;
      end
      OP_MTHI, OP_MTLO: begin
        op_valid = 1'b1;
      end
`ifdef MDU_MADD_EN
      // Accumulate against the HI/LO committed at accept time, wrapping in 64 bits.
      OP_MADD: begin
        res = {hi_q, lo_q} + prod_s; res_commit = 1'b1; op_valid = 1'b1; op_long = 1'b1;
      end
      OP_MSUB: begin
        res = {hi_q, lo_q} - prod_s; res_commit = 1'b1; op_valid = 1'b1; op_long = 1'b1;
      end
`else
      OP_MADD, OP_MSUB: begin
        op_valid = 1'b0;
      end
`endif
      default: begin
        op_valid = 1'b0;
      end
    endcase
  end

  assign accept = bus.Start && !bus.Req && (state == S_IDLE) && op_valid;

  // NOTE: state is updated with non-blocking assignments so every register in this
  // block samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      busy_q      <= 1'b0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      pend_hi     <= 32'd0;
      pend_lo     <= 32'd0;
      pend_commit <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            if (op_long) begin
              pend_hi     <= res[63:32];
              pend_lo     <= res[31:0];
              pend_commit <= res_commit;
              cnt         <= op_lat;
              busy_q      <= 1'b1;
              state       <= S_RUN;
            end else if (op == OP_MTHI) begin
              hi_q <= bus.A;
            end else begin
              lo_q <= bus.A;
            end
          end
        end
        S_RUN: begin
          // Start and Req are deliberately ignored here; an in-flight op always finishes.
          if (cnt == '0) begin
            if (pend_commit) begin
              hi_q <= pend_hi;
              lo_q <= pend_lo;
            end
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed cases followed by random ops against
// an arithmetic reference model of HI/LO and the Busy window.
module tb_mdu_iter;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic clk;
  logic reset;
  mdu_iter_if bus ();

  mdu_iter #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi, m_lo;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op at the current negedge and follow it to completion, checking Busy
  // every cycle and HI/LO against the model. poke pulses a stray MTHI mid-run.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic req, input logic poke);
    int              n;
    logic            commit;
    logic [63:0]     r;
    logic [31:0]     nhi, nlo;
    longint          sa, sb;
    longint unsigned ua, ub;
    n = 0; commit = 1'b0; r = 64'd0; nhi = m_hi; nlo = m_lo;
    sa = $signed(a); sb = $signed(b);
    ua = {32'b0, a}; ub = {32'b0, b};
    if (!req) begin
      case (op)
        3'd0: begin n = MUL_N; r = sa * sb; commit = 1'b1; end
        3'd1: begin n = MUL_N; r = ua * ub; commit = 1'b1; end
        3'd2: begin
          n = DIV_N;
          if (b != 0) begin r = {32'(sa % sb), 32'(sa / sb)}; commit = 1'b1; end
        end
        3'd3: begin
          n = DIV_N;
          if (b != 0) begin r = {32'(ua % ub), 32'(ua / ub)}; commit = 1'b1; end
        end
        3'd4: nhi = a;
        3'd5: nlo = a;
`ifdef MDU_MADD_EN
        3'd6: begin n = MUL_N; r = {m_hi, m_lo} + 64'(sa * sb); commit = 1'b1; end
        3'd7: begin n = MUL_N; r = {m_hi, m_lo} - 64'(sa * sb); commit = 1'b1; end
`endif
        default: ;
      endcase
    end
    if (commit) {nhi, nlo} = r;

    bus.Start = 1'b1; bus.Req = req; bus.MDUOp = op; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.Start = 1'b0; bus.Req = 1'b0;
    bus.A = $urandom; bus.B = $urandom; bus.MDUOp = 3'($urandom);
    for (int i = 0; i < n; i++) begin
      check($sformatf("busy_%0d", i), 32'(bus.Busy), 32'd1);
      if (i == 0) begin
        check("hi_hold", bus.HI, m_hi);
        check("lo_hold", bus.LO, m_lo);
      end
      if (poke && i == 1) begin
        bus.Start = 1'b1; bus.MDUOp = 3'd4; bus.A = $urandom;
      end else begin
        bus.Start = 1'b0;
      end
      @(negedge clk);
    end
    bus.Start = 1'b0;
    check("busy_done", 32'(bus.Busy), 32'd0);
    check("hi", bus.HI, nhi);
    check("lo", bus.LO, nlo);
    m_hi = nhi; m_lo = nlo;
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    bus.Req = 1'b0; bus.Start = 1'b0; bus.MDUOp = 3'd0; bus.A = 32'd0; bus.B = 32'd0;
    reset = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_hi", bus.HI, 32'd0);
    check("rst_lo", bus.LO, 32'd0);

    // MULT -2 * 3
    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    check("mult_hi", bus.HI, 32'hFFFF_FFFF);
    check("mult_lo", bus.LO, 32'hFFFF_FFFA);

    // DIV -7 / 2
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    check("div_lo", bus.LO, 32'hFFFF_FFFD);
    check("div_hi", bus.HI, 32'hFFFF_FFFF);

    // DIVU by zero leaves HI/LO alone
    run_op(3'd4, 32'h11, 32'd0, 1'b0, 1'b0);
    run_op(3'd5, 32'h22, 32'd0, 1'b0, 1'b0);
    run_op(3'd3, 32'd1234, 32'd0, 1'b0, 1'b0);
    check("div0_hi", bus.HI, 32'h11);
    check("div0_lo", bus.LO, 32'h22);

    // MTLO dropped under Req, then taken
    run_op(3'd5, 32'h1234, 32'd0, 1'b1, 1'b0);
    check("req_lo", bus.LO, 32'h22);
    run_op(3'd5, 32'h1234, 32'd0, 1'b0, 1'b0);
    check("mtlo_lo", bus.LO, 32'h1234);

    // DIV overflow case
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("ovf_lo", bus.LO, 32'h8000_0000);
    check("ovf_hi", bus.HI, 32'd0);

    // MULTU aborted by reset in busy cycle 3, then rerun
    bus.Start = 1'b1; bus.MDUOp = 3'd1; bus.A = 32'hFFFF_FFFF; bus.B = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(bus.Busy), 32'd0);
    check("abort_hi", bus.HI, 32'd0);
    check("abort_lo", bus.LO, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("multu_hi", bus.HI, 32'hFFFF_FFFE);
    check("multu_lo", bus.LO, 32'h0000_0001);

    // MADD wrapping LO into HI (a no-op when the feature is compiled out)
    run_op(3'd4, 32'd0, 32'd0, 1'b0, 1'b0);
    run_op(3'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    run_op(3'd6, 32'd1, 32'd1, 1'b0, 1'b0);
`ifdef MDU_MADD_EN
    check("madd_hi", bus.HI, 32'd1);
    check("madd_lo", bus.LO, 32'd0);
`else
    check("madd_off_hi", bus.HI, 32'd0);
    check("madd_off_lo", bus.LO, 32'hFFFF_FFFF);
`endif

    // Random ops, Req, divisor corner values and stray Starts during RUN
    for (int k = 0; k < 80; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        3: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(rop, ra, rb, ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
